scan_ctl: RTL and testbench
===========================

SCAN_CTL -- requirements
Module: scan_ctl

Interface
REQ-001 Parameter N, default 8, length of the dffhs scan chain driven by this block (bits), N >= 2.
REQ-002 Parameter CW, default 4, bit-counter width; SHALL satisfy 2**CW > N.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  one-cycle request to run a scan sequence; sampled only in IDLE.
REQ-006 CAP_EN  input  1  sampled with START; 1 = insert functional capture cycle, 0 = skip it.
REQ-007 PAT_IN  input  N  pattern to shift into the chain; sampled when START is accepted.
REQ-008 SCANOUT  input  1  serial output of chain, Q[N-1] of the last register.
REQ-009 TEST  output  1  drives chain TEST (1 = shift mode).
REQ-010 HOLD  output  1  drives chain HOLD (1 = registers retain value).
REQ-011 SCANIN  output  1  drives chain SCANIN.
REQ-012 BUSY  output  1  high from the cycle after START acceptance through the DONE cycle.
REQ-013 DONE  output  1  one-cycle pulse; RESULT valid.
REQ-014 RESULT  output  N  chain contents unloaded during SHIFT_OUT; held until next START is accepted.

Function
REQ-015 States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE; all outputs registered, driven from state and counter.
REQ-016 IDLE: TEST=0, HOLD=1, SCANIN=0, BUSY=0, DONE=0.
REQ-017 IDLE and START=1: latch PAT_IN into pattern register, latch CAP_EN, clear counter, go to SHIFT_IN.
REQ-018 SHIFT_IN: exactly N cycles, TEST=1, HOLD=0; cycle k (k=0..N-1) drives SCANIN=PAT[N-1-k], so after N chain edges Q equals PAT.
REQ-019 Last SHIFT_IN cycle: go to CAPTURE if latched CAP_EN=1, else SHIFT_OUT; counter cleared.
REQ-020 CAPTURE: exactly 1 cycle, TEST=0, HOLD=0, SCANIN=0 (chain loads functional D); then SHIFT_OUT.
REQ-021 SHIFT_OUT: exactly N cycles, TEST=1, HOLD=0, SCANIN=0; SCANOUT sampled on the rising edge ending each cycle and shifted into RESULT LSB (RESULT <= {RESULT[N-2:0], SCANOUT}), so RESULT[N-1] = first sample = pre-shift Q[N-1].
REQ-022 DONE: 1 cycle, DONE=1, BUSY=1, TEST=0, HOLD=1; then IDLE.
REQ-023 Sequence length from START edge to DONE pulse: 2N+2 cycles with CAP_EN=1, 2N+1 with CAP_EN=0.
REQ-024 START while BUSY is ignored; PAT_IN and CAP_EN changes while BUSY have no effect.
REQ-025 Counter counts 0..N-1 and clears on each state change; never wraps within a state.
REQ-026 RESULT changes only in SHIFT_OUT and on reset.

Reset
REQ-027 RST=1 at a rising edge forces IDLE, counter=0, pattern=0, RESULT=0, TEST=0, HOLD=1, SCANIN=0, BUSY=0, DONE=0.
REQ-028 RST takes priority over START and over any in-progress state; an aborted sequence produces no DONE.
REQ-029 First START SHALL be accepted on the first edge with RST=0.

Verification
REQ-030 N=8, chain model loops back (SCANOUT=Q[7]), CAP_EN=0, PAT_IN=8'hA5, START -> SCANIN sequence 1,0,1,0,0,1,0,1; DONE at cycle 17 after START; RESULT=8'hA5.
REQ-031 N=8, CAP_EN=1, chain functional D=8'h3C, PAT_IN=8'hFF -> one cycle TEST=0,HOLD=0 after 8 shift cycles; DONE at cycle 18; RESULT=8'h3C.
REQ-032 START pulsed again at cycles 3 and 17 of a running sequence -> ignored; exactly one DONE; BUSY stays high throughout.
REQ-033 RST asserted in SHIFT_OUT cycle 4 -> next cycle IDLE, RESULT=0, HOLD=1, TEST=0, no DONE; subsequent START with PAT_IN=8'h01 returns RESULT=8'h01.
REQ-034 RST and START both high on the same edge -> IDLE, BUSY=0; START on next edge with RST=0 accepted.
REQ-035 Back-to-back: START asserted in the cycle after DONE -> accepted; second RESULT replaces first only during its SHIFT_OUT.

Source files
------------

// File: rtl/scan_ctl_if.sv
// Signal bundle between scan_ctl, its requester and the dffhs scan chain.
// slave is the controller side; master is the environment (requester + chain).
interface scan_ctl_if #(parameter int N = 8);
  logic         start;
  logic         cap_en;
  logic [N-1:0] pat_in;
  logic         scanout;
  logic         test;
  logic         hold;
  logic         scanin;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport slave (
    input  start, cap_en, pat_in, scanout,
    output test, hold, scanin, busy, done, result
  );

  modport master (
    output start, cap_en, pat_in, scanout,
    input  test, hold, scanin, busy, done, result
  );
endinterface

// File: rtl/scan_ctl.sv
// Scan chain sequencer: shift pattern in, optional capture, shift result out, DONE pulse.
// DONE arrives 2N+1 (+1 with capture) cycles after START; START is ignored while busy.
module scan_ctl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input logic       clk,
  input logic       rst,
  scan_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0] pat, pat_nxt;
  logic         cap, cap_nxt;
  logic         test_nxt, hold_nxt, scanin_nxt, busy_nxt, done_nxt;
  logic         test_q, hold_q, scanin_q, busy_q, done_q;
  logic [N-1:0] result_q;
  logic         last;

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pat      <= '0;
      cap      <= 1'b0;
      test_q   <= 1'b0;
      hold_q   <= 1'b1;
      scanin_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pat      <= pat_nxt;
      cap      <= cap_nxt;
      test_q   <= test_nxt;
      hold_q   <= hold_nxt;
      scanin_q <= scanin_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  // Pattern register shifts left so its MSB is always the next bit to send.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pat_nxt   = pat;
    cap_nxt   = cap;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_SHIFT_IN;
          cnt_nxt   = '0;
          pat_nxt   = bus.pat_in;
          cap_nxt   = bus.cap_en;
        end
      end
      S_SHIFT_IN: begin
        pat_nxt = {pat[N-2:0], 1'b0};
        if (last) begin
          state_nxt = cap ? S_CAPTURE : S_SHIFT_OUT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_CAPTURE: begin
        state_nxt = S_SHIFT_OUT;
        cnt_nxt   = '0;
      end
      S_SHIFT_OUT: begin
        if (last) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copy lines up with it.
    test_nxt   = 1'b0;
    hold_nxt   = 1'b1;
    scanin_nxt = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state_nxt)
      S_SHIFT_IN: begin
        test_nxt   = 1'b1;
        hold_nxt   = 1'b0;
        scanin_nxt = pat_nxt[N-1];
        busy_nxt   = 1'b1;
      end
      S_CAPTURE: begin
        hold_nxt = 1'b0;
        busy_nxt = 1'b1;
      end
      S_SHIFT_OUT: begin
        test_nxt = 1'b1;
        hold_nxt = 1'b0;
        busy_nxt = 1'b1;
      end
      S_DONE: begin
        busy_nxt = 1'b1;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (state == S_SHIFT_OUT) begin
      result_q <= {result_q[N-2:0], bus.scanout};
    end
  end

  assign bus.test   = test_q;
  assign bus.hold   = hold_q;
  assign bus.scanin = scanin_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_scan_ctl.sv
// Directed bench for scan_ctl driving an 8-bit behavioural scan chain with loopback SCANOUT.
// Expected RESULT and DONE cycle are queued at START acceptance and checked on each DONE pulse.
module tb_scan_ctl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_ctl_if #(.N(N)) bus ();

  scan_ctl #(.N(N), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural dffhs chain: shift when TEST, load functional D otherwise, freeze on HOLD.
  logic [N-1:0] q;
  logic [N-1:0] dfn;
  always @(posedge clk) begin
    if (!bus.hold) q <= bus.test ? {q[N-2:0], bus.scanin} : dfn;
  end
  assign bus.scanout = q[N-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [N-1:0] res;
    int           at;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [N-1:0] p, input bit c, input logic [N-1:0] d);
    exp_t e;
    bus.pat_in = p;
    bus.cap_en = c;
    dfn        = d;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    check("accept_busy", 32'(bus.busy), 32'd1);
    e.res = c ? d : p;
    e.at  = cyc + 2 * N + (c ? 1 : 0);
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && bus.done !== 1'b1; i++) step();
    check("done_within_budget", 32'(bus.done), 32'd1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        done_cnt++;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_done: observed done at cycle %0d expected none", cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.at));
          check("result", 32'(bus.result), 32'(e.res));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] seq;
    bit           ok;
    int           dc0;

    bus.start  = 1'b0;
    bus.cap_en = 1'b0;
    bus.pat_in = '0;
    dfn        = '0;
    q          = '0;
    rst        = 1'b1;
    step();
    step();
    check("rst_test", 32'(bus.test), 32'd0);
    check("rst_hold", 32'(bus.hold), 32'd1);
    check("rst_scanin", 32'(bus.scanin), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);

    // Loopback, no capture; START accepted on the first edge after reset release.
    rst = 1'b0;
    start_seq(8'hA5, 1'b0, 8'h00);
    seq = '0;
    ok  = 1'b1;
    for (int k = 0; k < N; k++) begin
      seq = {seq[N-2:0], bus.scanin};
      ok  = ok && (bus.test === 1'b1) && (bus.hold === 1'b0);
      step();
    end
    check("shift_in_bits", 32'(seq), 32'hA5);
    check("shift_in_mode", 32'(ok), 32'd1);
    check("shift_out_test", 32'(bus.test), 32'd1);
    check("shift_out_scanin", 32'(bus.scanin), 32'd0);
    wait_done(40);
    step();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);

    // Capture of functional data.
    start_seq(8'hFF, 1'b1, 8'h3C);
    for (int k = 1; k < N; k++) step();
    check("last_shift_in_test", 32'(bus.test), 32'd1);
    step();
    check("capture_test", 32'(bus.test), 32'd0);
    check("capture_hold", 32'(bus.hold), 32'd0);
    step();
    check("after_capture_test", 32'(bus.test), 32'd1);
    wait_done(40);
    step();

    // START re-pulsed at cycles 3 and 17 of a running sequence.
    dc0 = done_cnt;
    start_seq(8'h5A, 1'b0, 8'h00);
    ok = 1'b1;
    for (int c = 1; c <= 2 * N + 1; c++) begin
      ok = ok && (bus.busy === 1'b1);
      bus.start = (c == 3 || c == 2 * N + 1);
      if (bus.start) begin
        bus.pat_in = 8'hFF;
        bus.cap_en = 1'b1;
      end
      step();
    end
    bus.start = 1'b0;
    check("busy_throughout", 32'(ok), 32'd1);
    check("restart_ignored", 32'(bus.busy), 32'd0);
    check("single_done", 32'(done_cnt - dc0), 32'd1);

    // Reset in the fourth SHIFT_OUT cycle aborts without DONE.
    start_seq(8'hC3, 1'b0, 8'h00);
    for (int c = 1; c < N + 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_hold", 32'(bus.hold), 32'd1);
    check("abort_test", 32'(bus.test), 32'd0);
    dc0 = done_cnt;
    for (int i = 0; i < 2 * N + 4; i++) step();
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    start_seq(8'h01, 1'b0, 8'h00);
    wait_done(40);
    step();

    // Reset wins over a simultaneous START.
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.pat_in = 8'h77;
    step();
    bus.start = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    check("rst_start_result", 32'(bus.result), 32'd0);
    rst = 1'b0;
    start_seq(8'h96, 1'b0, 8'h00);
    wait_done(40);

    // Back-to-back: START in the cycle after DONE; old RESULT held until SHIFT_OUT.
    step();
    check("b2b_idle", 32'(bus.busy), 32'd0);
    start_seq(8'h3E, 1'b1, 8'h81);
    ok = 1'b1;
    for (int c = 1; c <= N + 1; c++) begin
      ok = ok && (bus.result === 8'h96);
      step();
    end
    check("result_held", 32'(ok), 32'd1);
    wait_done(40);
    step();
    check("final_idle", 32'(bus.busy), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
